zaxxon_wave_fetch: RTL and testbench
====================================

Name: zaxxon_wave_fetch

Overview:
- Sample-playback front end between the Zaxxon sound trigger logic and the SDRAM wave port (wave_addr / wave_rd / 16-bit wave_data).
- Holds NUM_CH sample channels and generates the audio sample tick.
- On each tick, reads one 16-bit word per active channel from SDRAM over a round-robin fetch FSM.
- Mixes the channel samples with saturation into one signed 16-bit output that drives AUDIO_L/R.

Parameters:
- NUM_CH, 4: number of sample channels.
- ADDR_W, 20: wave byte-address width.
- RD_LAT, 6: clk_sys cycles from wave_rd high to wave_data valid. Fixed SDRAM read latency.
- SAMPLE_DIV, 544: clk_sys cycles per audio sample (24 MHz / 544 ≈ 44.1 kHz). Must satisfy SAMPLE_DIV > NUM_CH*(RD_LAT+3).

Ports:
- clk_sys  in  1  system clock, 24 MHz
- reset_n  in  1  asynchronous, active-low reset
- ch_start  in  NUM_CH  one-cycle pulse per channel: start playback
- ch_stop  in  NUM_CH  one-cycle pulse per channel: stop playback
- ch_loop  in  NUM_CH  per channel: restart at base when the end is reached
- ch_base  in  NUM_CH*ADDR_W  per-channel start byte address (bit 0 ignored)
- ch_len  in  NUM_CH*16  per-channel length in 16-bit words
- ch_active  out  NUM_CH  channel is playing
- wave_addr  out  ADDR_W  SDRAM byte address, always even
- wave_rd  out  1  one-cycle read strobe
- wave_data  in  16  SDRAM read data, signed little-endian sample
- audio_out  out  16  signed mixed sample, updated once per tick
- sample_tick  out  1  one-cycle pulse every SAMPLE_DIV cycles
- fetch_overrun  out  1  one-cycle pulse: a tick arrived while the FSM was not IDLE

Behaviour:
Reset values:
- Every output resets to 0. All channel positions, sample latches and the divider reset to 0.
- Reset is asynchronous. If it is asserted mid-fetch, wave_rd drops immediately and any pending capture is discarded.

Divider and tick:
- The divider counts 0..SAMPLE_DIV-1.
- sample_tick is high for the one cycle in which the count is SAMPLE_DIV-1.

Channel control, per channel at the clock edge:
- start latches base and len, sets pos=0, and sets active=1 only if len != 0.
- A start with len==0 leaves active=0.
- start while already active restarts the channel.
- stop clears active and zeroes the channel's sample latch.
- start and stop in the same cycle: stop wins.

Fetch FSM, states IDLE, ISSUE, WAIT, CAPTURE, MIX:
- IDLE: on sample_tick, snapshot ch_active into a pending mask, set ch_idx=0, go to ISSUE.
- ISSUE:
  - Channel ch_idx not pending: advance ch_idx.
  - Pending: drive wave_addr = base + 2*pos and wave_rd=1 for exactly one cycle, then go to WAIT.
  - When ch_idx passes NUM_CH-1: go to MIX.
- WAIT: count RD_LAT-1 cycles, then go to CAPTURE.
- CAPTURE:
  - Latch wave_data into the channel's sample register.
  - pos+1 == len with loop=1: pos wraps to 0.
  - pos+1 == len with loop=0: active cleared, and the sample latch is zeroed at the next MIX.
  - Otherwise pos increments.
  - Return to ISSUE with ch_idx+1.
  - A channel stopped while its fetch is in flight: the captured data is discarded.
- MIX:
  - audio_out = saturate16(sum of all sample latches). Sum width is 16+clog2(NUM_CH).
  - Clamp to +32767 / -32768.
  - Go to IDLE.

Latency and overrun:
- audio_out updates exactly 1 + k*(RD_LAT+2) + (NUM_CH-k) cycles after a tick, where k = number of pending channels.
- A tick arriving outside IDLE is dropped and fetch_overrun pulses for that cycle. This cannot happen if the SAMPLE_DIV constraint holds.
- wave_rd is never high on two consecutive cycles.

Decomposition:
- Package zaxxon_snd_pkg holds:
  - the FSM state enum (fetch_state_t);
  - the SAT_MAX and SAT_MIN constants;
  - a clog2-based sum-width constant function.
- One sub-module, wave_mix_sat: combinational NUM_CH-input signed adder with 16-bit saturation, instantiated in the MIX path.

Test Plan:
- Single shot: base=0x00100, len=3, loop=0, start ch0, SDRAM model returning 0x0100, 0x0200, 0x0300.
  - wave_rd addresses 0x100, 0x102, 0x104 on three successive ticks.
  - audio_out = 256, 512, 768, then 0.
  - ch_active[0] falls after the third capture.
- Loop wrap: len=2, loop=1.
  - Addresses alternate base, base+2 for 6 ticks.
  - ch_active stays 1.
  - ch_stop then gives audio_out=0 at the next tick.
- Saturation: 4 channels, all data 0x7000 → audio_out=0x7FFF. All data 0x9000 → audio_out=0x8000.
- Edge controls:
  - start with len=0 → ch_active stays 0 and no wave_rd.
  - start+stop in the same cycle → ch_active=0.
  - Restart mid-play → next address equals the new base.
- Timing: RD_LAT=6 with all 4 channels active.
  - audio_out updates 33 cycles after sample_tick.
  - Exactly 4 wave_rd pulses, spaced 8 cycles apart.
- Reset mid-WAIT: deassert reset_n during WAIT.
  - wave_rd, ch_active and audio_out are 0 asynchronously.
  - After release, the first tick issues no read.

Source files
------------

// File: rtl/zaxxon_snd_pkg.sv
// Shared types and constants for the Zaxxon sample-playback front end.
package zaxxon_snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_MIX     = 3'd4
  } fetch_state_t;

  localparam int SAMPLE_W = 16;
  localparam int SAT_MAX  = 32767;
  localparam int SAT_MIN  = -32768;

  // Mixer accumulator width: one sample plus enough headroom for every channel.
  function automatic int mix_sum_w(input int n);
    return SAMPLE_W + $clog2(n);
  endfunction

  // Channel index width, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wave_mix_sat.sv
// Combinational signed mixer: sums NUM_CH 16-bit samples and clamps to 16 bits.
module wave_mix_sat
  import zaxxon_snd_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH*16-1:0] samp_flat,
  output logic [15:0]          mix
);

  localparam int SUM_W = mix_sum_w(NUM_CH);

  logic signed [SUM_W-1:0] sum;
  logic        [15:0]      s;

  // Wide signed sum, then clamp into the 16-bit range.
  always_comb begin
    sum = '0;
    s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s   = samp_flat[i*16 +: 16];
      sum = sum + SUM_W'($signed(s));
    end
    if (sum > SUM_W'(SAT_MAX)) begin
      mix = 16'(SAT_MAX);
    end else if (sum < SUM_W'(SAT_MIN)) begin
      mix = 16'(SAT_MIN);
    end else begin
      mix = sum[15:0];
    end
  end

endmodule

// File: rtl/zaxxon_wave_fetch.sv
// Zaxxon sample playback: per-channel control, audio tick divider, round-robin
// SDRAM fetch FSM and saturating mixer driving the audio output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for sample_tick; snapshots active channels on tick
// ISSUE   | skip a non-pending channel, or fire one wave_rd for it
// WAIT    | down-count RD_LAT cycles while SDRAM returns the word
// CAPTURE | latch wave_data, advance/wrap/end the channel position
// MIX     | register the saturated sum of all sample latches
module zaxxon_wave_fetch
  import zaxxon_snd_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 20,
  parameter int RD_LAT     = 6,
  parameter int SAMPLE_DIV = 544
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_stop,
  input  logic [NUM_CH-1:0]        ch_loop,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*16-1:0]     ch_len,
  output logic [NUM_CH-1:0]        ch_active,
  output logic [ADDR_W-1:0]        wave_addr,
  output logic                     wave_rd,
  input  logic [15:0]              wave_data,
  output logic [15:0]              audio_out,
  output logic                     sample_tick,
  output logic                     fetch_overrun
);

  localparam int IDX_W  = idx_w(NUM_CH);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WCNT_W = $clog2(RD_LAT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [DIV_W-1:0]  DIV_TC   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WCNT_W-1:0] WAIT_LD  = WCNT_W'(RD_LAT - 1);

  fetch_state_t state_q, state_d;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              abort_q, abort_d;

  logic [NUM_CH-1:0] active_q, active_d;
  logic [ADDR_W-1:0] base_q [NUM_CH];
  logic [ADDR_W-1:0] base_d [NUM_CH];
  logic [15:0]       len_q  [NUM_CH];
  logic [15:0]       len_d  [NUM_CH];
  logic [15:0]       pos_q  [NUM_CH];
  logic [15:0]       pos_d  [NUM_CH];
  logic [15:0]       samp_q [NUM_CH];
  logic [15:0]       samp_d [NUM_CH];

  logic              wave_rd_q, wave_rd_d;
  logic [ADDR_W-1:0] wave_addr_q, wave_addr_d;
  logic [15:0]       audio_q, audio_d;

  logic                tick;
  logic                cur_pend;
  logic                cur_ctrl;
  logic                capture_ok;
  logic                mix_en;
  logic [15:0]         mix_val;
  logic [NUM_CH*16-1:0] samp_flat;

  assign tick     = (div_q == DIV_TC);
  assign cur_pend = pend_q[idx_q] & active_q[idx_q];
  assign cur_ctrl = ch_start[idx_q] | ch_stop[idx_q];

  // Free-running audio divider, wraps at SAMPLE_DIV-1.
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the channel walk and read-latency timer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          pend_d  = active_q;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cur_pend) begin
          wcnt_d  = WAIT_LD;
          state_d = ST_WAIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_MIX;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_MIX;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_MIX: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: read strobe/address, capture qualifier, mix enable.
  // A start or stop on the channel in flight poisons its capture.
  always_comb begin
    wave_rd_d   = (state_q == ST_ISSUE) && cur_pend;
    wave_addr_d = wave_addr_q;
    if (wave_rd_d) begin
      wave_addr_d = (base_q[idx_q] + ADDR_W'({pos_q[idx_q], 1'b0})) & ~ADDR_W'(1);
    end
    abort_d = 1'b0;
    if (state_q == ST_ISSUE) begin
      abort_d = cur_pend && cur_ctrl;
    end else if (state_q == ST_WAIT) begin
      abort_d = abort_q || cur_ctrl;
    end
    capture_ok = (state_q == ST_CAPTURE) && !abort_q && !cur_ctrl;
    mix_en     = (state_q == ST_MIX);
    audio_d    = mix_en ? mix_val : audio_q;
  end

  // Per-channel control and position bookkeeping; stop overrides start.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active_d[i] = active_q[i];
      base_d[i]   = base_q[i];
      len_d[i]    = len_q[i];
      pos_d[i]    = pos_q[i];
      samp_d[i]   = samp_q[i];
      if (mix_en && !active_q[i]) begin
        samp_d[i] = '0;
      end
      if (capture_ok && (idx_q == IDX_W'(i))) begin
        samp_d[i] = wave_data;
        if ((pos_q[i] + 16'd1) == len_q[i]) begin
          pos_d[i] = '0;
          if (!ch_loop[i]) begin
            active_d[i] = 1'b0;
          end
        end else begin
          pos_d[i] = pos_q[i] + 16'd1;
        end
      end
      if (ch_stop[i]) begin
        active_d[i] = 1'b0;
        samp_d[i]   = '0;
      end else if (ch_start[i]) begin
        base_d[i]   = ch_base[i*ADDR_W +: ADDR_W];
        len_d[i]    = ch_len[i*16 +: 16];
        pos_d[i]    = '0;
        active_d[i] = (ch_len[i*16 +: 16] != 16'd0);
      end
    end
  end

  // Flatten the sample latches for the mixer.
  always_comb begin
    samp_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      samp_flat[i*16 +: 16] = samp_q[i];
    end
  end

  wave_mix_sat #(
    .NUM_CH(NUM_CH)
  ) u_mix (
    .samp_flat(samp_flat),
    .mix      (mix_val)
  );

  // Datapath and channel registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      wcnt_q      <= '0;
      abort_q     <= 1'b0;
      active_q    <= '0;
      wave_rd_q   <= 1'b0;
      wave_addr_q <= '0;
      audio_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        pos_q[i]  <= '0;
        samp_q[i] <= '0;
      end
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      wcnt_q      <= wcnt_d;
      abort_q     <= abort_d;
      active_q    <= active_d;
      wave_rd_q   <= wave_rd_d;
      wave_addr_q <= wave_addr_d;
      audio_q     <= audio_d;
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= base_d[i];
        len_q[i]  <= len_d[i];
        pos_q[i]  <= pos_d[i];
        samp_q[i] <= samp_d[i];
      end
    end
  end

  assign ch_active     = active_q;
  assign wave_rd       = wave_rd_q;
  assign wave_addr     = wave_addr_q;
  assign audio_out     = audio_q;
  assign sample_tick   = tick;
  assign fetch_overrun = tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_zaxxon_wave_fetch.sv
// Directed bench for zaxxon_wave_fetch with a fixed-latency SDRAM model.
module tb_zaxxon_wave_fetch;

  localparam int NCH = 4;
  localparam int AW  = 20;
  localparam int LAT = 6;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    ch_start = '0;
  logic [NCH-1:0]    ch_stop  = '0;
  logic [NCH-1:0]    ch_loop  = '0;
  logic [NCH*AW-1:0] ch_base  = '0;
  logic [NCH*16-1:0] ch_len   = '0;
  logic [NCH-1:0]    ch_active;
  logic [AW-1:0]     wave_addr;
  logic              wave_rd;
  logic [15:0]       wave_data;
  logic [15:0]       audio_out;
  logic              sample_tick;
  logic              fetch_overrun;

  int checks = 0;
  int errors = 0;

  zaxxon_wave_fetch dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ch_start     (ch_start),
    .ch_stop      (ch_stop),
    .ch_loop      (ch_loop),
    .ch_base      (ch_base),
    .ch_len       (ch_len),
    .ch_active    (ch_active),
    .wave_addr    (wave_addr),
    .wave_rd      (wave_rd),
    .wave_data    (wave_data),
    .audio_out    (audio_out),
    .sample_tick  (sample_tick),
    .fetch_overrun(fetch_overrun)
  );

  always #10 clk_sys = ~clk_sys;

  // SDRAM model: word looked up at the read strobe, valid LAT cycles later.
  logic [15:0] mem [512];
  logic [15:0] pipe [LAT];
  always @(posedge clk_sys) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= wave_rd ? mem[wave_addr[9:1]] : 16'hDEAD;
  end
  assign wave_data = pipe[LAT-1];

  // Bus monitor.
  int cyc = 0;
  int consec_cnt = 0;
  int ovr_cnt = 0;
  logic prev_rd = 1'b0;
  logic [AW-1:0] rd_addr_q [$];
  int rd_cyc_q [$];
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) begin
    if (wave_rd) begin
      rd_addr_q.push_back(wave_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (wave_rd && prev_rd) consec_cnt++;
    if (fetch_overrun) ovr_cnt++;
    prev_rd = wave_rd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [AW-1:0] b, input logic [15:0] l, input logic lp);
    ch_base[c*AW +: AW] = b;
    ch_len[c*16 +: 16]  = l;
    ch_loop[c]          = lp;
  endtask

  task automatic pulse(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    ch_start = st;
    ch_stop  = sp;
    @(negedge clk_sys);
    ch_start = '0;
    ch_stop  = '0;
  endtask

  task automatic wait_tick();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk_sys);
      if (sample_tick) begin
        got = 1'b1;
        break;
      end
    end
    chk("tick_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic frame();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    wait_tick();
    repeat (40) @(negedge clk_sys);
  endtask

  function automatic logic [31:0] first_addr();
    return (rd_addr_q.size() > 0) ? 32'(rd_addr_q[0]) : 32'hFFFFFFFF;
  endfunction

  logic [15:0] prev_audio;
  int t0;
  int lat;
  logic found;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem['h100 >> 1] = 16'h0100;
    mem['h102 >> 1] = 16'h0200;
    mem['h104 >> 1] = 16'h0300;
    mem['h200 >> 1] = 16'h0011;
    mem['h202 >> 1] = 16'h0022;
    mem['h300 >> 1] = 16'h7000;
    mem['h310 >> 1] = 16'h7000;
    mem['h320 >> 1] = 16'h7000;
    mem['h330 >> 1] = 16'h7000;
    mem['h180 >> 1] = 16'h0055;
    mem['h182 >> 1] = 16'h0066;

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_active", 32'(ch_active), 32'h0);
    chk("rst_rd", 32'(wave_rd), 32'h0);
    chk("rst_addr", 32'(wave_addr), 32'h0);
    chk("rst_audio", 32'(audio_out), 32'h0);
    chk("rst_tick", 32'(sample_tick), 32'h0);
    chk("rst_ovr", 32'(fetch_overrun), 32'h0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single shot, ch0
    set_ch(0, 20'h00100, 16'd3, 1'b0);
    pulse(4'b0001, 4'b0000);
    chk("ss_active0", 32'(ch_active), 32'h1);
    frame();
    chk("ss_addr1", first_addr(), 32'h100);
    chk("ss_audio1", 32'(audio_out), 32'd256);
    frame();
    chk("ss_addr2", first_addr(), 32'h102);
    chk("ss_audio2", 32'(audio_out), 32'd512);
    chk("ss_active2", 32'(ch_active), 32'h1);
    frame();
    chk("ss_addr3", first_addr(), 32'h104);
    chk("ss_audio3", 32'(audio_out), 32'd768);
    chk("ss_active3", 32'(ch_active), 32'h0);
    frame();
    chk("ss_nrd4", 32'(rd_addr_q.size()), 32'd0);
    chk("ss_audio4", 32'(audio_out), 32'd0);

    // Loop wrap, ch1
    set_ch(1, 20'h00200, 16'd2, 1'b1);
    pulse(4'b0010, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      frame();
      chk("loop_addr", first_addr(), (i % 2 == 0) ? 32'h200 : 32'h202);
      chk("loop_audio", 32'(audio_out), (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    chk("loop_active", 32'(ch_active), 32'h2);
    pulse(4'b0000, 4'b0010);
    frame();
    chk("loop_stop_audio", 32'(audio_out), 32'h0);
    chk("loop_stop_active", 32'(ch_active), 32'h0);

    // Saturation high, all four channels
    set_ch(0, 20'h00300, 16'd1, 1'b1);
    set_ch(1, 20'h00310, 16'd1, 1'b1);
    set_ch(2, 20'h00320, 16'd1, 1'b1);
    set_ch(3, 20'h00330, 16'd1, 1'b1);
    pulse(4'b1111, 4'b0000);
    frame();
    chk("sat_hi_audio", 32'(audio_out), 32'h7FFF);
    chk("sat_hi_nrd", 32'(rd_addr_q.size()), 32'd4);

    // Saturation low plus fetch timing
    mem['h300 >> 1] = 16'h9000;
    mem['h310 >> 1] = 16'h9000;
    mem['h320 >> 1] = 16'h9000;
    mem['h330 >> 1] = 16'h9000;
    rd_addr_q.delete();
    rd_cyc_q.delete();
    wait_tick();
    t0 = cyc;
    prev_audio = audio_out;
    lat = 0;
    @(posedge clk_sys);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_sys);
      #1;
      if (audio_out !== prev_audio) begin
        lat = n;
        break;
      end
    end
    @(negedge clk_sys);
    chk("timing_latency", 32'(lat), 32'd33);
    repeat (10) @(negedge clk_sys);
    chk("sat_lo_audio", 32'(audio_out), 32'h8000);
    chk("timing_nrd", 32'(rd_cyc_q.size()), 32'd4);
    if (rd_cyc_q.size() == 4) begin
      chk("timing_first_rd", 32'(rd_cyc_q[0] - t0), 32'd2);
      chk("timing_gap01", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'd8);
      chk("timing_gap12", 32'(rd_cyc_q[2] - rd_cyc_q[1]), 32'd8);
      chk("timing_gap23", 32'(rd_cyc_q[3] - rd_cyc_q[2]), 32'd8);
    end
    pulse(4'b0000, 4'b1111);
    chk("stop_all_active", 32'(ch_active), 32'h0);

    // Edge controls
    set_ch(2, 20'h00200, 16'd0, 1'b0);
    pulse(4'b0100, 4'b0000);
    chk("len0_active", 32'(ch_active), 32'h0);
    frame();
    chk("len0_nrd", 32'(rd_addr_q.size()), 32'd0);
    chk("len0_audio", 32'(audio_out), 32'h0);
    set_ch(3, 20'h00200, 16'd5, 1'b0);
    pulse(4'b1000, 4'b1000);
    chk("startstop_active", 32'(ch_active), 32'h0);

    // Restart mid-play
    set_ch(0, 20'h00100, 16'd3, 1'b0);
    pulse(4'b0001, 4'b0000);
    frame();
    chk("rs_addr1", first_addr(), 32'h100);
    chk("rs_audio1", 32'(audio_out), 32'h100);
    set_ch(0, 20'h00180, 16'd2, 1'b1);
    pulse(4'b0001, 4'b0000);
    frame();
    chk("rs_addr2", first_addr(), 32'h180);
    chk("rs_audio2", 32'(audio_out), 32'h55);

    // Asynchronous reset during WAIT
    wait_tick();
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_sys);
      if (wave_rd) begin
        found = 1'b1;
        break;
      end
    end
    chk("arst_rd_seen", {31'b0, found}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_rd", 32'(wave_rd), 32'h0);
    chk("arst_active", 32'(ch_active), 32'h0);
    chk("arst_audio", 32'(audio_out), 32'h0);
    chk("arst_addr", 32'(wave_addr), 32'h0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    frame();
    chk("arst_post_nrd", 32'(rd_addr_q.size()), 32'd0);
    chk("arst_post_audio", 32'(audio_out), 32'h0);

    chk("rd_never_back_to_back", 32'(consec_cnt), 32'd0);
    chk("no_overrun", 32'(ovr_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
